fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined core: the initiator side of the instruction-memory read port. Holds the program counter, drives the word address to instruction memory (combinational, same-cycle read), captures the returned instruction into the IF/ID pipeline register, and handles decode back-pressure, branch redirects, and a halt/resume control state.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word aligned.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; always word aligned, bits [1:0] = 0.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- id_ready  in  1  decode accepts the IF/ID register this cycle.
- redirect  in  1  branch/jump taken; load new PC and squash fetched instruction.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced to 0).
- halt_req  in  1  stop fetching after the current cycle.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_instr  out  32  captured instruction.
- if_id_pc  out  32  address of captured instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4, modulo 2^32.
- halted  out  1  high in STOP state.
- fetch_count  out  32  count of instructions accepted by decode; wraps.

## Operation
- States: BOOT, RUN, STOP. Reset -> BOOT. BOOT -> RUN unconditionally next cycle (one bubble after reset release, no capture).
- imem_addr = pc at all times (registered PC, no combinational input path).
- RUN, no redirect, advance condition adv = !if_id_valid | id_ready:
  - adv: IF/ID <= {1, imem_instr, pc, pc+4}; pc <= pc + 4.
  - !adv: pc and IF/ID hold.
- redirect (any state, highest priority): pc <= {redirect_pc[31:2], 2'b00}; if_id_valid <= 0; state <= RUN; halt_req same cycle ignored.
- halt_req in RUN without redirect: state <= STOP; current instruction still captured if adv; pc advances normally that cycle.
- STOP: pc frozen, no new capture; existing IF/ID entry drains when id_ready (if_id_valid <= 0). Leave only via redirect.
- fetch_count increments when if_id_valid & id_ready & !redirect.
- PC arithmetic is 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000. Memory aliasing above its depth is the memory's concern; fetch does not check range.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, if_id_valid = 0, if_id_instr = 0, if_id_pc = 0, if_id_pc_plus4 = 0, halted = 0, fetch_count = 0, state = BOOT. Reset asserted mid-operation takes effect immediately, regardless of clock.
- Fetch latency: instruction at pc appears in IF/ID one edge after pc is presented (given adv).
- Redirect asserted before edge N: pc = target after N; target instruction valid in IF/ID after N+1 (one bubble).
- First instruction after reset release: valid in IF/ID after second rising edge (BOOT bubble).
- Steady-state throughput: one instruction per cycle with id_ready high.
- halted asserts the cycle after halt_req is sampled; deasserts the cycle after redirect.

## Structure
- Shared core package: XLEN = 32, INSTR_BYTES = 4, fetch state enum (BOOT, RUN, STOP), IF/ID payload struct {valid, instr, pc, pc_plus4} reused by decode.
- One natural sub-module: if_id_reg (enable + synchronous clear pipeline register with async reset); PC/state logic stays in fetch_unit.

## Test plan
- Reset release, RESET_PC = 0, id_ready = 1, memory words i at addr 4i: IF/ID shows pc 0,4,8,... with instr 0,1,2 from 2nd edge; fetch_count = 3 after three accepts.
- id_ready low for 3 cycles with if_id_pc = 8: imem_addr stays 12, IF/ID holds pc 8, fetch_count unchanged; resumes with pc 12 next.
- redirect with redirect_pc = 32'h0000_0103 while id_ready = 0: next cycle if_id_valid = 0, imem_addr = 32'h100; following cycle IF/ID pc = 32'h100.
- halt_req at pc 20: instruction at 20 captured, halted = 1, imem_addr frozen at 24, IF/ID drains to invalid; redirect to 0x40 resumes, halted = 0.
- PC = 32'hFFFF_FFFC: if_id_pc_plus4 = 0, next imem_addr = 0.
- Assert rst_n low mid-stall: outputs return to reset values immediately without clock edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_unit_pkg: shared core types for the instruction-fetch stage.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_unit_if: imem read port, decode handshake and control of fetch. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            id_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            halt_req;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic            halted;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
           halted, fetch_count,
    input  imem_instr, id_ready, redirect, redirect_pc, halt_req
  );

  modport slave (
    input  imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
           halted, fetch_count,
    output imem_instr, id_ready, redirect, redirect_pc, halt_req
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_unit_if_id_reg: IF/ID pipeline register, enable + sync clear.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst_n,
  input  wire logic   i_en,
  input  wire logic   i_clr,
  input  wire if_id_t i_d,
  output if_id_t      o_q
);

  if_id_t r_q;

  // Clear only kills the valid bit; the stale payload is harmless once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q.valid <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_unit: PC, fetch state machine and IF/ID capture.                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input wire logic     clk,
  input wire logic     rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_fetch_count;
  logic            w_adv;
  logic            w_cap;
  logic            w_clr;
  if_id_t          w_if_id_d;
  if_id_t          w_if_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign w_adv = !w_if_id_q.valid || bus.id_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cap       = 1'b0;
    w_clr       = 1'b0;
    if (bus.redirect) begin
      w_state_nxt = RUN;
      w_pc_nxt    = pc_align(bus.redirect_pc);
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        BOOT: w_state_nxt = RUN;
        RUN: begin
          if (w_adv) begin
            w_cap    = 1'b1;
            w_pc_nxt = pc_next(r_pc);
          end
          if (bus.halt_req) begin
            w_state_nxt = STOP;
          end
        end
        STOP: w_clr = bus.id_ready;
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  assign w_if_id_d = '{valid: 1'b1, instr: bus.imem_instr, pc: r_pc,
                       pc_plus4: pc_next(r_pc)};

  fetch_unit_if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_cap),
    .i_clr (w_clr),
    .i_d   (w_if_id_d),
    .o_q   (w_if_id_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_if_id_q.valid && bus.id_ready && !bus.redirect) begin
      r_fetch_count <= r_fetch_count + XLEN'(1);
    end
  end

  assign bus.imem_addr      = r_pc;
  assign bus.if_id_valid    = w_if_id_q.valid;
  assign bus.if_id_instr    = w_if_id_q.instr;
  assign bus.if_id_pc       = w_if_id_q.pc;
  assign bus.if_id_pc_plus4 = w_if_id_q.pc_plus4;
  assign bus.halted         = (r_state == STOP);
  assign bus.fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fetch_unit: directed + random stimulus against a behavioural model.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory holds word index i at byte address 4i.
  assign bus.imem_instr = bus.imem_addr >> 2;

  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
  logic        m_valid, m_stop, m_boot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_stop = 1'b0; m_boot = 1'b1;
  endtask

  // One rising edge worth of fetch behaviour, from the stage's rules.
  task automatic model_edge();
    if (m_valid && bus.id_ready && !bus.redirect) m_cnt = m_cnt + 1;
    if (bus.redirect) begin
      m_pc = {bus.redirect_pc[31:2], 2'b00};
      m_valid = 1'b0; m_stop = 1'b0; m_boot = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_stop) begin
      if (bus.id_ready) m_valid = 1'b0;
    end else begin
      if (!m_valid || bus.id_ready) begin
        m_valid = 1'b1; m_instr = m_pc / 4; m_ipc = m_pc; m_pc = m_pc + 4;
      end
      if (bus.halt_req) m_stop = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("valid", 32'(bus.if_id_valid), 32'(m_valid));
    chk("halted", 32'(bus.halted), 32'(m_stop));
    chk("fetch_count", bus.fetch_count, m_cnt);
    if (m_valid) begin
      chk("if_id_instr", bus.if_id_instr, m_instr);
      chk("if_id_pc", bus.if_id_pc, m_ipc);
      chk("if_id_pc_plus4", bus.if_id_pc_plus4, m_ipc + 32'd4);
    end
  endtask

  task automatic check_reset();
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
    chk("rst_instr", bus.if_id_instr, 32'h0);
    chk("rst_pc", bus.if_id_pc, 32'h0);
    chk("rst_pc_plus4", bus.if_id_pc_plus4, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_fetch_count", bus.fetch_count, 32'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.halt_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    bus.id_ready = 1'b1;

    // Boot bubble then streaming: pc 0,4,8
    cycle();
    chk("boot_bubble", 32'(bus.if_id_valid), 32'h0);
    cycle();
    chk("first_pc", bus.if_id_pc, 32'h0);
    cycle(); cycle();
    chk("stream_pc", bus.if_id_pc, 32'h8);
    chk("stream_addr", bus.imem_addr, 32'hC);

    bus.id_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("stall_addr", bus.imem_addr, 32'hC);
      chk("stall_pc", bus.if_id_pc, 32'h8);
    end
    bus.id_ready = 1'b1;
    cycle();
    chk("resume_pc", bus.if_id_pc, 32'hC);

    bus.id_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    cycle();
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_squash", 32'(bus.if_id_valid), 32'h0);
    bus.redirect = 1'b0;
    cycle();
    chk("redir_target", bus.if_id_pc, 32'h100);

    bus.id_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    cycle();
    bus.redirect = 1'b0;
    cycle();
    chk("wrap_pc4", bus.if_id_pc_plus4, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    bus.redirect = 1'b1; bus.redirect_pc = 32'd20;
    cycle();
    bus.redirect = 1'b0; bus.halt_req = 1'b1;
    cycle();
    bus.halt_req = 1'b0;
    chk("halt_cap", bus.if_id_pc, 32'd20);
    chk("halt_flag", 32'(bus.halted), 32'h1);
    chk("halt_addr", bus.imem_addr, 32'd24);
    cycle(); cycle();
    chk("halt_drain", 32'(bus.if_id_valid), 32'h0);
    chk("halt_frozen", bus.imem_addr, 32'd24);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    cycle();
    bus.redirect = 1'b0;
    chk("resume_halted", 32'(bus.halted), 32'h0);

    for (int i = 0; i < 600; i++) begin
      bus.id_ready = ($urandom_range(0, 9) < 7);
      bus.redirect = ($urandom_range(0, 9) == 0);
      bus.halt_req = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      cycle();
    end

    // Asynchronous reset during a stall, between clock edges
    bus.redirect = 1'b0; bus.halt_req = 1'b0; bus.id_ready = 1'b0;
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    repeat (6) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
